// File: rtl/pipeline_control_unit_pkg.sv
// Shared types and constants for the MIPS pipeline control unit.
// Used by the interface, the top level and the hazard detection sub-module.
package pipeline_control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam int NB_REG_DEFAULT = 5;

  // Opcode the ID stage decodes into halt_instr.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Handshake bundle between the debug unit / ID stage and the pipeline control unit.
// Optional macro PIPE_CTRL_STATS_EN adds the stall and flush statistic counters.
interface pipeline_control_unit_if
  import pipeline_control_unit_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = NB_REG_DEFAULT
);

  logic              start_i;
  logic              step_i;
  logic              halt_instr_i;
  logic [NB_REG-1:0] id_rs_i;
  logic [NB_REG-1:0] id_rt_i;
  logic [NB_REG-1:0] ex_rt_i;
  logic              ex_mem_read_i;
  logic              branch_taken_i;

  logic               en_pipeline_o;
  logic               pc_write_o;
  logic               if_id_write_o;
  logic               if_id_flush_o;
  logic               id_ex_bubble_o;
  logic               halted_o;
  logic [NB_DATA-1:0] cycle_count_o;
`ifdef PIPE_CTRL_STATS_EN
  logic [NB_DATA-1:0] stall_count_o;
  logic [NB_DATA-1:0] flush_count_o;
`endif

  modport master (
    output start_i, step_i, halt_instr_i, id_rs_i, id_rt_i, ex_rt_i,
           ex_mem_read_i, branch_taken_i,
    input  en_pipeline_o, pc_write_o, if_id_write_o, if_id_flush_o,
           id_ex_bubble_o, halted_o, cycle_count_o
`ifdef PIPE_CTRL_STATS_EN
    , input stall_count_o, flush_count_o
`endif
  );

  modport slave (
    input  start_i, step_i, halt_instr_i, id_rs_i, id_rt_i, ex_rt_i,
           ex_mem_read_i, branch_taken_i,
    output en_pipeline_o, pc_write_o, if_id_write_o, if_id_flush_o,
           id_ex_bubble_o, halted_o, cycle_count_o
`ifdef PIPE_CTRL_STATS_EN
    , output stall_count_o, flush_count_o
`endif
  );

endinterface

// File: rtl/pipeline_control_unit_hazard_detection_unit.sv
// Combinational load-use hazard detector: a load in EX whose destination feeds
// the instruction in ID forces a one-cycle stall. Writes to $zero never stall.
module pipeline_control_unit_hazard_detection_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEFAULT
) (
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall
);

  assign stall = ex_mem_read
               && (ex_rt != NB_REG'(REG_ZERO))
               && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_control_unit.sv
// Central sequencer for the 5-stage MIPS pipeline: run/step/halt FSM plus hazard-driven write/flush/bubble.
// Optional macro PIPE_CTRL_STATS_EN adds stall and flush statistic counters.
module pipeline_control_unit
  import pipeline_control_unit_pkg::*;
#(
  parameter int NB_DATA      = 32,
  parameter int NB_REG       = NB_REG_DEFAULT,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                   clock_i,
  input logic                   reset_i,
  pipeline_control_unit_if.slave bus
);

  localparam int NB_DRAIN = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [NB_DRAIN-1:0] DRAIN_INIT = NB_DRAIN'(DRAIN_CYCLES);
  localparam logic [NB_DRAIN-1:0] DRAIN_ONE  = NB_DRAIN'(1);

  state_t              state;
  state_t              state_next;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic [NB_DRAIN-1:0] drain_next;
  logic [NB_DATA-1:0]  cycle_cnt;
  logic                step_prev;
  logic                step_rise;
  logic                stall;
  logic                enable;
  logic                freeze;
  logic                halted;

  assign step_rise = bus.step_i & ~step_prev;

  pipeline_control_unit_hazard_detection_unit #(
    .NB_REG (NB_REG)
  ) u_hazard (
    .ex_mem_read (bus.ex_mem_read_i),
    .ex_rt       (bus.ex_rt_i),
    .id_rs       (bus.id_rs_i),
    .id_rt       (bus.id_rt_i),
    .stall       (stall)
  );

  // freeze keeps the front end closed from the cycle HALT is seen in ID onward.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    enable     = 1'b0;
    freeze     = 1'b0;
    halted     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i)    state_next = ST_RUN;
        else if (step_rise) state_next = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        enable = 1'b1;
        if (bus.halt_instr_i) begin
          freeze     = 1'b1;
          state_next = ST_DRAIN;
          drain_next = DRAIN_INIT;
        end else if ((state == ST_STEP) || !bus.start_i) begin
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        freeze = 1'b1;
        if (drain_cnt == '0) begin
          state_next = ST_HALTED;
        end else begin
          enable = bus.start_i | step_rise;
          if (enable) begin
            drain_next = drain_cnt - DRAIN_ONE;
            if (drain_cnt == DRAIN_ONE) state_next = ST_HALTED;
          end
        end
      end
      ST_HALTED: halted = 1'b1;
      default:   state_next = ST_IDLE;
    endcase
    if (reset_i) begin
      enable = 1'b0;
      halted = 1'b0;
    end
  end

  assign bus.en_pipeline_o  = enable;
  assign bus.pc_write_o     = enable & ~stall & ~freeze;
  assign bus.if_id_write_o  = enable & ~stall & ~freeze;
  assign bus.if_id_flush_o  = enable & ~stall & ~freeze & bus.branch_taken_i;
  assign bus.id_ex_bubble_o = enable & stall;
  assign bus.halted_o       = halted;
  assign bus.cycle_count_o  = cycle_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      step_prev <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      step_prev <= bus.step_i;
      if (enable) cycle_cnt <= cycle_cnt + NB_DATA'(1);
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  logic [NB_DATA-1:0] stall_cnt;
  logic [NB_DATA-1:0] flush_cnt;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.id_ex_bubble_o) stall_cnt <= stall_cnt + NB_DATA'(1);
      if (bus.if_id_flush_o)  flush_cnt <= flush_cnt + NB_DATA'(1);
    end
  end

  assign bus.stall_count_o = stall_cnt;
  assign bus.flush_count_o = flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: randomized debug/hazard stimulus against a behavioural model.
// Stat counters are also checked when PIPE_CTRL_STATS_EN is defined.
module tb_pipeline_control_unit;

  localparam int NB_DATA      = 32;
  localparam int NB_REG       = 5;
  localparam int DRAIN_CYCLES = 3;

  typedef struct {
    bit          en;
    bit          pc;
    bit          ifid;
    bit          flush;
    bit          bubble;
    bit          halted;
    logic [31:0] count;
    bit          count_known;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } exp_t;

  bit   clk = 1'b0;
  logic rst;
  bit   stim_done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // Behavioural model of the debug modes and halt drain.
  bit          m_running;
  bit          m_stepping;
  bit          m_halted;
  int          m_drain_left;
  bit          m_last_step;
  bit          m_count_known;
  int unsigned m_cycles;
  int unsigned m_stalls;
  int unsigned m_flushes;

  pipeline_control_unit_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG)) bus ();

  pipeline_control_unit #(
    .NB_DATA      (NB_DATA),
    .NB_REG       (NB_REG),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input bit start_v, input bit step_v,
                               input bit halt_v, input bit memread_v, input bit branch_v,
                               input logic [4:0] rs_v, input logic [4:0] rt_v,
                               input logic [4:0] exrt_v);
    exp_t e;
    bit   rise, hazard, en, closed;
    rst                = rst_v;
    bus.start_i        = start_v;
    bus.step_i         = step_v;
    bus.halt_instr_i   = halt_v;
    bus.ex_mem_read_i  = memread_v;
    bus.branch_taken_i = branch_v;
    bus.id_rs_i        = rs_v;
    bus.id_rt_i        = rt_v;
    bus.ex_rt_i        = exrt_v;

    rise   = step_v && !m_last_step;
    hazard = memread_v && (exrt_v != 5'd0) && ((exrt_v == rs_v) || (exrt_v == rt_v));
    if (m_halted)               en = 1'b0;
    else if (m_drain_left >= 0) en = (m_drain_left > 0) && (start_v || rise);
    else                        en = m_running || m_stepping;
    if (rst_v) en = 1'b0;
    closed = (m_drain_left >= 0) || (halt_v && (m_running || m_stepping));

    e.en          = en;
    e.bubble      = en && hazard;
    e.pc          = en && !hazard && !closed;
    e.ifid        = e.pc;
    e.flush       = e.pc && branch_v;
    e.halted      = m_halted && !rst_v;
    e.count       = m_cycles;
    e.count_known = m_count_known;
    e.stalls      = m_stalls;
    e.flushes     = m_flushes;
    sb.push_back(e);

    @(posedge clk);
    if (rst_v) begin
      m_running = 0; m_stepping = 0; m_halted = 0; m_drain_left = -1;
      m_last_step = 0; m_count_known = 1; m_cycles = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (en)       m_cycles++;
      if (e.bubble) m_stalls++;
      if (e.flush)  m_flushes++;
      if (m_halted) begin
      end else if (m_drain_left >= 0) begin
        if (m_drain_left == 0 || (en && m_drain_left == 1)) begin
          m_halted = 1; m_drain_left = -1;
        end else if (en) begin
          m_drain_left--;
        end
      end else if (m_running || m_stepping) begin
        if (halt_v) begin
          m_drain_left = DRAIN_CYCLES; m_running = 0; m_stepping = 0;
        end else if (m_stepping) begin
          m_stepping = 0;
        end else if (!start_v) begin
          m_running = 0;
        end
      end else begin
        if (start_v)   m_running = 1;
        else if (rise) m_stepping = 1;
      end
      m_last_step = step_v;
    end
    #1;
  endtask

  task automatic randCycle(input bit rst_v, input bit start_v, input bit step_v, input bit halt_v);
    applyStimulus(rst_v, start_v, step_v, halt_v, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
  endtask

  task automatic quiet(input bit start_v, input bit step_v, input bit halt_v, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, start_v, step_v, halt_v, 0, 0, 5'd1, 5'd2, 5'd3);
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    int   grace = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("en_pipeline", 32'(bus.en_pipeline_o), 32'(e.en));
        checkOutput("pc_write", 32'(bus.pc_write_o), 32'(e.pc));
        checkOutput("if_id_write", 32'(bus.if_id_write_o), 32'(e.ifid));
        checkOutput("if_id_flush", 32'(bus.if_id_flush_o), 32'(e.flush));
        checkOutput("id_ex_bubble", 32'(bus.id_ex_bubble_o), 32'(e.bubble));
        checkOutput("halted", 32'(bus.halted_o), 32'(e.halted));
        if (e.count_known) begin
          checkOutput("cycle_count", bus.cycle_count_o, e.count);
`ifdef PIPE_CTRL_STATS_EN
          checkOutput("stall_count", bus.stall_count_o, e.stalls);
          checkOutput("flush_count", bus.flush_count_o, e.flushes);
`endif
        end
      end else if (stim_done) begin
        break;
      end
      if (stim_done) begin
        grace++;
        if (grace > 8) begin
          checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
          break;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    m_running = 0; m_stepping = 0; m_halted = 0; m_drain_left = -1;
    m_last_step = 0; m_count_known = 0; m_cycles = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset and idle");
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    quiet(0, 0, 0, 3);

    $display("[TB] continuous run, no hazards");
    quiet(1, 0, 0, 10);
    quiet(0, 0, 0, 2);

    $display("[TB] directed load-use and branch cases");
    quiet(1, 0, 0, 2);
    applyStimulus(0, 1, 0, 0, 1, 0, 5'd5, 5'd7, 5'd5);
    applyStimulus(0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 1, 0, 0, 1, 0, 5'd9, 5'd5, 5'd5);
    applyStimulus(0, 1, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3);
    applyStimulus(0, 1, 0, 0, 1, 1, 5'd4, 5'd6, 5'd4);
    applyStimulus(0, 1, 0, 0, 0, 1, 5'd4, 5'd6, 5'd4);

    $display("[TB] randomized run");
    for (int i = 0; i < 150; i++) randCycle(0, ($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1, 0);
    quiet(0, 0, 0, 3);

    $display("[TB] single-step pulses and held step");
    for (int p = 0; p < 3; p++) begin
      quiet(0, 1, 0, 1);
      quiet(0, 0, 0, 3);
    end
    quiet(0, 1, 0, 5);
    quiet(0, 0, 0, 3);

    $display("[TB] randomized step/run mix");
    for (int i = 0; i < 200; i++) randCycle(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 2) == 0, 0);
    quiet(0, 0, 0, 2);

    $display("[TB] halt from run");
    quiet(1, 0, 0, 3);
    quiet(1, 0, 1, 1);
    for (int i = 0; i < 10; i++) randCycle(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) randCycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);

    $display("[TB] halt from single-step");
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    quiet(0, 1, 0, 1);
    quiet(0, 0, 1, 2);
    for (int p = 0; p < 5; p++) begin
      quiet(0, 1, 0, 1);
      quiet(0, 0, 0, 2);
    end

    $display("[TB] randomized episodes with resets and halts");
    for (int ep = 0; ep < 6; ep++) begin
      int start_pct = $urandom_range(20, 90);
      applyStimulus(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 150; i++)
        randCycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < start_pct),
                  $urandom_range(0, 2) == 0, ($urandom_range(0, 49) == 0));
    end

    stim_done = 1'b1;
  end

endmodule
